// File: rtl/nand_cmd_scheduler_if.sv
// nand_cmd_scheduler_if
//   Command bus between the scheduler and the NAND flash controller core.
//   master : scheduler side (drives the command fields, oCmdValid, oAbort)
//   slave  : core side (drives iCmdReady, iCmdDone, iCmdFail)
// Signals:
//   oCmd/oAddr/oLen/oDMAR/oDMAW  command fields presented with oCmdValid
//   oCmdValid / iCmdReady        issue handshake
//   iCmdDone / iCmdFail          completion pulses (fail also completes)
//   oAbort                       one-cycle abort pulse on WAIT timeout
interface nand_cmd_scheduler_if;
    logic [31:0] oCmd;
    logic [31:0] oAddr;
    logic [15:0] oLen;
    logic [31:0] oDMAR;
    logic [31:0] oDMAW;
    logic        oCmdValid;
    logic        iCmdReady;
    logic        iCmdDone;
    logic        iCmdFail;
    logic        oAbort;

    modport master (
        output oCmd, oAddr, oLen, oDMAR, oDMAW, oCmdValid, oAbort,
        input  iCmdReady, iCmdDone, iCmdFail
    );

    modport slave (
        input  oCmd, oAddr, oLen, oDMAR, oDMAW, oCmdValid, oAbort,
        output iCmdReady, iCmdDone, iCmdFail
    );
endinterface

// File: rtl/nand_cmd_scheduler.sv
// nand_cmd_scheduler
//   Queues software command writes in a DEPTH-entry FIFO and issues them to
//   the NAND controller core one at a time, waiting for completion between
//   commands. Keeps sticky drop/fail/timeout status and a saturating fail
//   counter for software readback.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   iCommand..iDMAWAddress     command fields, pushed on iCommandValid
//   iFlush                     discard queued, not-yet-issued entries
//   iClearStatus               clear sticky status and the fail counter
//   core                       command bus to the core (master modport)
//   oBusy, oQueueCount, oQueueFull   activity and occupancy
//   oDropped, oCommandFail, oTimeout, oFailCount, oLastFailCmd   status
// Build option:
//   NAND_CMD_SCHED_TIMEOUT_EN  adds the WAIT timeout counter and oAbort;
//                              otherwise oAbort/oTimeout are tied low.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | nothing in flight; loads the queue head when one exists
// S_ISSUE | head presented with oCmdValid, waiting for iCmdReady
// S_WAIT  | command accepted, waiting for done/fail (or timeout)
module nand_cmd_scheduler #(
    parameter int          DEPTH          = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            iCommand,
    input  logic                   iCommandValid,
    input  logic [31:0]            iAddress,
    input  logic [15:0]            iLength,
    input  logic [31:0]            iDMARAddress,
    input  logic [31:0]            iDMAWAddress,
    input  logic                   iFlush,
    input  logic                   iClearStatus,
    nand_cmd_scheduler_if.master   core,
    output logic                   oBusy,
    output logic [$clog2(DEPTH):0] oQueueCount,
    output logic                   oQueueFull,
    output logic                   oDropped,
    output logic                   oCommandFail,
    output logic                   oTimeout,
    output logic [7:0]             oFailCount,
    output logic [31:0]            oLastFailCmd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] cmd;
        logic [31:0] addr;
        logic [15:0] len;
        logic [31:0] dmar;
        logic [31:0] dmaw;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        state, state_nxt;
    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          pop, push_room, push_ok, push_drop, load_head;
    logic          wait_exit, wait_fail, timeout_hit, fail_event;

    assign head      = mem[rd_ptr];
    assign pop       = (state == S_ISSUE) && core.iCmdReady;
    assign load_head = (state == S_IDLE) && (oQueueCount != '0) && !iFlush;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_room = (oQueueCount < CW'(DEPTH)) || pop;
    assign push_ok   = iCommandValid && !iFlush && push_room;
    assign push_drop = iCommandValid && !iFlush && !push_room;
    assign wait_exit = (state == S_WAIT) && (core.iCmdDone || core.iCmdFail);
    assign wait_fail = (state == S_WAIT) && core.iCmdFail;
    assign fail_event = wait_fail || timeout_hit;

`ifdef NAND_CMD_SCHED_TIMEOUT_EN
    logic [23:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (pop)
            wait_cnt <= '0;
        else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 24'd1;
    end

    // A completion in the same cycle beats the timeout.
    assign timeout_hit = (state == S_WAIT) && (wait_cnt == TIMEOUT_CYCLES) && !wait_exit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            oTimeout <= 1'b0;
        else if (timeout_hit)
            oTimeout <= 1'b1;
        else if (iClearStatus)
            oTimeout <= 1'b0;
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign oTimeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load_head) state_nxt = S_ISSUE;
            S_ISSUE: if (core.iCmdReady) state_nxt = S_WAIT;
            S_WAIT:  if (wait_exit || timeout_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        core.oCmdValid = (state == S_ISSUE);
        core.oAbort    = timeout_hit;
        oBusy          = (state != S_IDLE) || (oQueueCount != '0);
    end

    assign oQueueFull = (oQueueCount == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= '{iCommand, iAddress, iLength, iDMARAddress, iDMAWAddress};
    end

    // The head being presented in ISSUE counts as queued until its handshake,
    // but a flush must not discard it, so it survives as the only entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            oQueueCount <= '0;
        end else if (iFlush) begin
            rd_ptr      <= rd_ptr + AW'(pop);
            wr_ptr      <= rd_ptr + AW'(state == S_ISSUE);
            oQueueCount <= CW'((state == S_ISSUE) && !pop);
        end else begin
            rd_ptr      <= rd_ptr + AW'(pop);
            wr_ptr      <= wr_ptr + AW'(push_ok);
            oQueueCount <= oQueueCount + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core.oCmd  <= '0;
            core.oAddr <= '0;
            core.oLen  <= '0;
            core.oDMAR <= '0;
            core.oDMAW <= '0;
        end else if (load_head) begin
            core.oCmd  <= head.cmd;
            core.oAddr <= head.addr;
            core.oLen  <= head.len;
            core.oDMAR <= head.dmar;
            core.oDMAW <= head.dmaw;
        end
    end

    // Set events win over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oDropped     <= 1'b0;
            oCommandFail <= 1'b0;
            oFailCount   <= '0;
            oLastFailCmd <= '0;
        end else begin
            if (push_drop)
                oDropped <= 1'b1;
            else if (iClearStatus)
                oDropped <= 1'b0;

            if (fail_event) begin
                oCommandFail <= 1'b1;
                oLastFailCmd <= core.oCmd;
                if (iClearStatus)
                    oFailCount <= 8'd1;
                else if (oFailCount != 8'hFF)
                    oFailCount <= oFailCount + 8'd1;
            end else if (iClearStatus) begin
                oCommandFail <= 1'b0;
                oFailCount   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_nand_cmd_scheduler.sv
module tb_nand_cmd_scheduler;
    localparam int          DEPTH  = 4;
    localparam logic [23:0] TO_CYC = 24'd16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iCommand, iAddress, iDMARAddress, iDMAWAddress;
    logic [15:0] iLength;
    logic        iCommandValid, iFlush, iClearStatus;
    logic        oBusy, oQueueFull, oDropped, oCommandFail, oTimeout;
    logic [$clog2(DEPTH):0] oQueueCount;
    logic [7:0]  oFailCount;
    logic [31:0] oLastFailCmd;

    nand_cmd_scheduler_if bus ();

    nand_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .iCommand(iCommand), .iCommandValid(iCommandValid), .iAddress(iAddress),
        .iLength(iLength), .iDMARAddress(iDMARAddress), .iDMAWAddress(iDMAWAddress),
        .iFlush(iFlush), .iClearStatus(iClearStatus), .core(bus),
        .oBusy(oBusy), .oQueueCount(oQueueCount), .oQueueFull(oQueueFull),
        .oDropped(oDropped), .oCommandFail(oCommandFail), .oTimeout(oTimeout),
        .oFailCount(oFailCount), .oLastFailCmd(oLastFailCmd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        iCommandValid = 1'b0; iCommand = '0; iAddress = '0; iLength = '0;
        iDMARAddress = '0; iDMAWAddress = '0; iFlush = 1'b0; iClearStatus = 1'b0;
        bus.iCmdReady = 1'b0; bus.iCmdDone = 1'b0; bus.iCmdFail = 1'b0;
    endtask

    task automatic push_in(input logic [31:0] cmd, input logic [31:0] addr);
        iCommandValid = 1'b1;
        iCommand      = cmd;
        iAddress      = addr;
        iLength       = cmd[15:0] + 16'd1;
        iDMARAddress  = addr ^ 32'hA000_0000;
        iDMAWAddress  = addr ^ 32'hB000_0000;
    endtask

    task automatic check_zero(input string name);
        logic any;
        any = |{bus.oCmd, bus.oAddr, bus.oLen, bus.oDMAR, bus.oDMAW, bus.oCmdValid,
                bus.oAbort, oBusy, oQueueCount, oQueueFull, oDropped, oCommandFail,
                oTimeout, oFailCount, oLastFailCmd};
        chk(name, 32'(any), 32'd0);
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.oCmdValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic pulse_done();
        bus.iCmdDone = 1'b1;
        step();
        bus.iCmdDone = 1'b0;
    endtask

    task automatic handshake();
        bus.iCmdReady = 1'b1;
        step();
        bus.iCmdReady = 1'b0;
    endtask

    typedef struct {
        logic        push;
        logic [31:0] cmd;
        logic [31:0] addr;
        logic        ready, done, fail, clear;
        int          e_cnt;
        logic        e_valid, e_busy;
        logic [31:0] e_cmd, e_addr;
        logic        e_fail;
        int          e_fcnt;
        logic [31:0] e_last;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic [31:0] c, input logic [31:0] a,
                                input logic r, input logic d, input logic f, input logic cl,
                                input int ec, input logic ev, input logic eb,
                                input logic [31:0] ecmd, input logic [31:0] eaddr,
                                input logic ef, input int efc, input logic [31:0] el);
        vec_t v;
        v.push = p; v.cmd = c; v.addr = a; v.ready = r; v.done = d; v.fail = f; v.clear = cl;
        v.e_cnt = ec; v.e_valid = ev; v.e_busy = eb; v.e_cmd = ecmd; v.e_addr = eaddr;
        v.e_fail = ef; v.e_fcnt = efc; v.e_last = el;
        return v;
    endfunction

    vec_t tbl [11];

    // Reference model state for the random phase.
    logic [31:0] mq [$];
    bit          m_pres, m_wait, m_drop, m_cfail, m_to;
    int          m_wcnt, m_fcnt;
    logic [31:0] m_out, m_last;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          r_push, r_ready, r_done, r_fail, r_flush, r_clear;
        bit          pres_b, pop, exit_ok, to_ev, fail_ev, drop;
        logic [31:0] r_cmd, keep;
        int          qsz_b, k_abort, seen;

        idle_in();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- table: single command, fail path, clear ----------
        tbl[0]  = mk(1, 32'h90, 32'h1234, 1, 0, 0, 0, 1, 0, 1, 0,     0,      0, 0, 0);
        tbl[1]  = mk(0, 0,      0,        1, 0, 0, 0, 1, 1, 1, 32'h90, 32'h1234, 0, 0, 0);
        tbl[2]  = mk(0, 0,      0,        1, 0, 0, 0, 0, 0, 1, 32'h90, 32'h1234, 0, 0, 0);
        tbl[3]  = mk(0, 0,      0,        0, 1, 0, 0, 0, 0, 0, 32'h90, 32'h1234, 0, 0, 0);
        tbl[4]  = mk(1, 32'hA5, 32'h55,   0, 0, 0, 0, 1, 0, 1, 32'h90, 32'h1234, 0, 0, 0);
        tbl[5]  = mk(0, 0,      0,        0, 0, 0, 0, 1, 1, 1, 32'hA5, 32'h55,   0, 0, 0);
        tbl[6]  = mk(0, 0,      0,        0, 0, 0, 0, 1, 1, 1, 32'hA5, 32'h55,   0, 0, 0);
        tbl[7]  = mk(0, 0,      0,        1, 0, 0, 0, 0, 0, 1, 32'hA5, 32'h55,   0, 0, 0);
        tbl[8]  = mk(0, 0,      0,        0, 1, 1, 0, 0, 0, 0, 32'hA5, 32'h55,   1, 1, 32'hA5);
        tbl[9]  = mk(0, 0,      0,        0, 0, 0, 1, 0, 0, 0, 32'hA5, 32'h55,   0, 0, 0);
        tbl[10] = mk(0, 0,      0,        0, 1, 1, 0, 0, 0, 0, 32'hA5, 32'h55,   0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            idle_in();
            if (tbl[i].push) push_in(tbl[i].cmd, tbl[i].addr);
            bus.iCmdReady = tbl[i].ready;
            bus.iCmdDone  = tbl[i].done;
            bus.iCmdFail  = tbl[i].fail;
            iClearStatus  = tbl[i].clear;
            step();
            chk($sformatf("tbl%0d_count", i), 32'(oQueueCount), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.oCmdValid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_busy", i), 32'(oBusy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_cmd", i), bus.oCmd, tbl[i].e_cmd);
            chk($sformatf("tbl%0d_addr", i), bus.oAddr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_cmdfail", i), 32'(oCommandFail), 32'(tbl[i].e_fail));
            chk($sformatf("tbl%0d_failcnt", i), 32'(oFailCount), 32'(tbl[i].e_fcnt));
            if (tbl[i].e_fail)
                chk($sformatf("tbl%0d_lastfail", i), oLastFailCmd, tbl[i].e_last);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_len", i), 32'(bus.oLen), 32'(tbl[i].e_cmd[15:0] + 16'd1));
                chk($sformatf("tbl%0d_dmar", i), bus.oDMAR, tbl[i].e_addr ^ 32'hA000_0000);
                chk($sformatf("tbl%0d_dmaw", i), bus.oDMAW, tbl[i].e_addr ^ 32'hB000_0000);
            end
        end
        idle_in();

        // ---------------- overflow: DEPTH+1 pushes with core stalled -------
        for (int i = 0; i <= DEPTH; i++) begin
            push_in(32'h10 + 32'(i), 32'h100 + 32'(i));
            step();
        end
        idle_in();
        chk("ovf_count", 32'(oQueueCount), 32'(DEPTH));
        chk("ovf_full", 32'(oQueueFull), 32'd1);
        chk("ovf_dropped", 32'(oDropped), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            wait_valid($sformatf("ovf_wait%0d", i));
            chk($sformatf("ovf_order%0d", i), bus.oCmd, 32'h10 + 32'(i));
            chk($sformatf("ovf_addr%0d", i), bus.oAddr, 32'h100 + 32'(i));
            handshake();
            chk($sformatf("ovf_validdrop%0d", i), 32'(bus.oCmdValid), 32'd0);
            pulse_done();
        end
        chk("ovf_idle_busy", 32'(oBusy), 32'd0);

        // ---------------- full queue with a push in the handshake cycle ----
        iClearStatus = 1'b1;
        step();
        iClearStatus = 1'b0;
        chk("clr_dropped", 32'(oDropped), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            push_in(32'h20 + 32'(i), 32'h200);
            step();
        end
        chk("fp_full", 32'(oQueueFull), 32'd1);
        push_in(32'h20 + 32'(DEPTH), 32'h200);
        bus.iCmdReady = 1'b1;
        step();
        idle_in();
        chk("fp_count", 32'(oQueueCount), 32'(DEPTH));
        chk("fp_dropped", 32'(oDropped), 32'd0);
        pulse_done();
        for (int i = 1; i <= DEPTH; i++) begin
            wait_valid($sformatf("fp_wait%0d", i));
            chk($sformatf("fp_order%0d", i), bus.oCmd, 32'h20 + 32'(i));
            handshake();
            pulse_done();
        end
        chk("fp_idle_busy", 32'(oBusy), 32'd0);

        // ---------------- flush with one command in WAIT -------------------
        push_in(32'h30, 32'h300);
        step();
        idle_in();
        wait_valid("fl_wait");
        handshake();
        for (int i = 1; i <= 3; i++) begin
            push_in(32'h30 + 32'(i), 32'h300);
            step();
        end
        idle_in();
        chk("fl_count_before", 32'(oQueueCount), 32'd3);
        iFlush = 1'b1;
        step();
        iFlush = 1'b0;
        chk("fl_count_after", 32'(oQueueCount), 32'd0);
        chk("fl_busy_inflight", 32'(oBusy), 32'd1);
        pulse_done();
        chk("fl_busy_done", 32'(oBusy), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.oCmdValid === 1'b1) seen++;
        end
        chk("fl_no_issue", 32'(seen), 32'd0);

        // ---------------- long WAIT: timeout or indefinite -----------------
        push_in(32'h40, 32'h400);
        step();
        idle_in();
        wait_valid("to_wait");
        handshake();
`ifdef NAND_CMD_SCHED_TIMEOUT_EN
        k_abort = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.oAbort === 1'b1) begin
                k_abort = k;
                break;
            end
        end
        chk("to_abort_delay", 32'(k_abort), 32'd16);
        step();
        chk("to_abort_pulse", 32'(bus.oAbort), 32'd0);
        chk("to_timeout", 32'(oTimeout), 32'd1);
        chk("to_failcnt", 32'(oFailCount), 32'd1);
        chk("to_cmdfail", 32'(oCommandFail), 32'd1);
        chk("to_lastfail", oLastFailCmd, 32'h40);
        chk("to_busy", 32'(oBusy), 32'd0);
        iClearStatus = 1'b1;
        step();
        iClearStatus = 1'b0;
        chk("to_clear", 32'(oTimeout), 32'd0);
`else
        k_abort = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.oAbort !== 1'b0) k_abort++;
        end
        chk("nto_abort", 32'(k_abort), 32'd0);
        chk("nto_busy", 32'(oBusy), 32'd1);
        chk("nto_timeout", 32'(oTimeout), 32'd0);
        pulse_done();
        chk("nto_failcnt", 32'(oFailCount), 32'd0);
        chk("nto_idle", 32'(oBusy), 32'd0);
`endif

        // ---------------- reset while in WAIT ------------------------------
        push_in(32'h50, 32'h500);
        step();
        push_in(32'h51, 32'h510);
        step();
        idle_in();
        wait_valid("rst_wait");
        handshake();
        repeat (3) step();
        chk("rst_pre_busy", 32'(oBusy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid_wait");
        do_reset();

        // ---------------- random traffic against the reference model -------
        mq.delete();
        m_pres = 0; m_wait = 0; m_drop = 0; m_cfail = 0; m_to = 0;
        m_wcnt = 0; m_fcnt = 0; m_out = '0; m_last = '0;
        for (int c = 0; c < 600; c++) begin
            r_push  = ($urandom % 3) == 0;
            r_cmd   = $urandom;
            r_ready = ($urandom % 2) == 0;
            r_done  = ($urandom % 4) == 0;
            r_fail  = ($urandom % 8) == 0;
            r_flush = ($urandom % 25) == 0;
            r_clear = ($urandom % 20) == 0;

            idle_in();
            if (r_push) push_in(r_cmd, ~r_cmd);
            bus.iCmdReady = r_ready;
            bus.iCmdDone  = r_done;
            bus.iCmdFail  = r_fail;
            iFlush        = r_flush;
            iClearStatus  = r_clear;

            pres_b  = m_pres;
            qsz_b   = mq.size();
            pop     = m_pres && r_ready;
            exit_ok = m_wait && (r_done || r_fail);
            to_ev   = 1'b0;
`ifdef NAND_CMD_SCHED_TIMEOUT_EN
            if (m_wait && !exit_ok && m_wcnt == int'(TO_CYC)) to_ev = 1'b1;
`endif
            fail_ev = (m_wait && r_fail) || to_ev;
            drop    = 1'b0;

            if (m_pres) begin
                if (r_ready) begin m_pres = 0; m_wait = 1; m_wcnt = 0; end
            end else if (m_wait) begin
                if (exit_ok || to_ev) m_wait = 0;
                else m_wcnt++;
            end else if (qsz_b > 0 && !r_flush) begin
                m_pres = 1;
                m_out  = mq[0];
            end

            if (pop) void'(mq.pop_front());
            if (r_flush) begin
                if (pres_b && !pop) begin
                    keep = mq[0];
                    mq.delete();
                    mq.push_back(keep);
                end else begin
                    mq.delete();
                end
            end else if (r_push) begin
                if (mq.size() < DEPTH) mq.push_back(r_cmd);
                else drop = 1'b1;
            end

            if (fail_ev) begin
                m_cfail = 1;
                m_fcnt  = r_clear ? 1 : (m_fcnt == 255 ? 255 : m_fcnt + 1);
                m_last  = m_out;
            end else if (r_clear) begin
                m_cfail = 0;
                m_fcnt  = 0;
            end
            if (drop) m_drop = 1;
            else if (r_clear) m_drop = 0;
            if (to_ev) m_to = 1;
            else if (r_clear) m_to = 0;

            step();
            chk("rnd_count", 32'(oQueueCount), 32'(mq.size()));
            chk("rnd_full", 32'(oQueueFull), 32'(mq.size() == DEPTH));
            chk("rnd_valid", 32'(bus.oCmdValid), 32'(m_pres));
            chk("rnd_busy", 32'(oBusy), 32'(m_pres || m_wait || mq.size() > 0));
            chk("rnd_cmd", bus.oCmd, m_out);
            chk("rnd_dropped", 32'(oDropped), 32'(m_drop));
            chk("rnd_cmdfail", 32'(oCommandFail), 32'(m_cfail));
            chk("rnd_failcnt", 32'(oFailCount), 32'(m_fcnt));
            chk("rnd_lastfail", oLastFailCmd, m_last);
            chk("rnd_timeout", 32'(oTimeout), 32'(m_to));
        end
        idle_in();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
